// File: rtl/mem_stage_access.sv
// mem_stage_access
//
// Memory-stage access unit fed by the EXE/MEM pipeline register. Loads and
// stores go out over a handshaked, variable-latency data memory port; the
// upstream pipeline is stalled while an access is outstanding. Results and
// control are registered into the MEM/WB stage on the falling clock edge.
//
// Ports
//   clk_i, rst_ni        pipeline clock (state on falling edge), async active-low reset
//   alu_data_i           effective address or ALU result
//   write_data_i         store data
//   write_src_i          destination register
//   next_pc4_i           PC+4
//   mem_write_i          store request (wins when both access bits are set)
//   mem_read_i           load request
//   mem_to_reg_i         writeback select, passed through
//   reg_write_i          register write enable, passed through
//   mem_req_o            memory request valid (registered)
//   mem_we_o             1 = store
//   mem_addr_o           word address
//   mem_wdata_o          store data
//   mem_rdata_i          load data, valid with mem_ack_i
//   mem_ack_i            one-cycle completion strobe
//   mem_stall_o          combinational stall for PC, IF/ID, ID/EXE, EXE/MEM
//   mem_fault_o          one-cycle pulse on misaligned access or ack timeout
//   wb_*_o               MEM/WB pipeline register outputs

module mem_stage_access #(
    parameter int unsigned AckTimeout = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic [31:0] alu_data_i,
    input  logic [31:0] write_data_i,
    input  logic [4:0]  write_src_i,
    input  logic [31:0] next_pc4_i,
    input  logic        mem_write_i,
    input  logic        mem_read_i,
    input  logic [1:0]  mem_to_reg_i,
    input  logic        reg_write_i,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,

    output logic        mem_stall_o,
    output logic        mem_fault_o,

    output logic [31:0] wb_alu_data_o,
    output logic [31:0] wb_read_data_o,
    output logic [31:0] wb_next_pc4_o,
    output logic [4:0]  wb_write_src_o,
    output logic [1:0]  wb_mem_to_reg_o,
    output logic        wb_reg_write_o
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;

    // Access copies held stable on the memory port until ack or abort
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    // Instruction fields captured at issue, written to MEM/WB on completion
    logic [4:0]  src_q;
    logic [31:0] pc4_q;
    logic [1:0]  m2r_q;
    logic        rw_q;

    logic        fault_q;
    logic [31:0] wb_alu_q;
    logic [31:0] wb_rd_q;
    logic [31:0] wb_pc4_q;
    logic [4:0]  wb_src_q;
    logic [1:0]  wb_m2r_q;
    logic        wb_rw_q;

    logic is_access;
    logic misaligned;
    logic cnt_last;
    logic timeout_hit;

    assign is_access   = mem_read_i | mem_write_i;
    assign misaligned  = is_access && (alu_data_i[1:0] != 2'b00);
    assign cnt_last    = (cnt_q == 8'(AckTimeout - 1));
    // Ack on the final allowed cycle still completes the access
    assign timeout_hit = (state_q == StAccess) && !mem_ack_i && cnt_last;

    // Stall is combinational so the upstream registers freeze in the same
    // cycle the access is detected. Held low during reset so nothing upstream
    // stays frozen while the stage is being cleared.
    always_comb begin
        mem_stall_o = 1'b0;
        unique case (state_q)
            StIdle:   mem_stall_o = is_access && !misaligned;
            StAccess: mem_stall_o = !mem_ack_i && !timeout_hit;
            default:  mem_stall_o = 1'b0;
        endcase
        if (!rst_ni) begin
            mem_stall_o = 1'b0;
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            src_q    <= 5'd0;
            pc4_q    <= 32'd0;
            m2r_q    <= 2'd0;
            rw_q     <= 1'b0;
            fault_q  <= 1'b0;
            wb_alu_q <= 32'd0;
            wb_rd_q  <= 32'd0;
            wb_pc4_q <= 32'd0;
            wb_src_q <= 5'd0;
            wb_m2r_q <= 2'd0;
            wb_rw_q  <= 1'b0;
        end else begin
            // Default: MEM/WB takes a bubble and the fault pulse clears
            fault_q  <= 1'b0;
            wb_alu_q <= 32'd0;
            wb_rd_q  <= 32'd0;
            wb_pc4_q <= 32'd0;
            wb_src_q <= 5'd0;
            wb_m2r_q <= 2'd0;
            wb_rw_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (!is_access) begin
                        wb_alu_q <= alu_data_i;
                        wb_pc4_q <= next_pc4_i;
                        wb_src_q <= write_src_i;
                        wb_m2r_q <= mem_to_reg_i;
                        wb_rw_q  <= reg_write_i;
                    end else if (misaligned) begin
                        fault_q <= 1'b1;
                    end else begin
                        state_q <= StAccess;
                        cnt_q   <= 8'd0;
                        addr_q  <= alu_data_i;
                        wdata_q <= write_data_i;
                        we_q    <= mem_write_i;
                        src_q   <= write_src_i;
                        pc4_q   <= next_pc4_i;
                        m2r_q   <= mem_to_reg_i;
                        rw_q    <= reg_write_i;
                    end
                end

                StAccess: begin
                    if (mem_ack_i) begin
                        state_q  <= StIdle;
                        wb_alu_q <= addr_q;
                        wb_rd_q  <= we_q ? 32'd0 : mem_rdata_i;
                        wb_pc4_q <= pc4_q;
                        wb_src_q <= src_q;
                        wb_m2r_q <= m2r_q;
                        wb_rw_q  <= rw_q;
                    end else if (cnt_last) begin
                        state_q <= StIdle;
                        fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_req_o       = (state_q == StAccess);
    assign mem_we_o        = we_q;
    assign mem_addr_o      = addr_q;
    assign mem_wdata_o     = wdata_q;
    assign mem_fault_o     = fault_q;

    assign wb_alu_data_o   = wb_alu_q;
    assign wb_read_data_o  = wb_rd_q;
    assign wb_next_pc4_o   = wb_pc4_q;
    assign wb_write_src_o  = wb_src_q;
    assign wb_mem_to_reg_o = wb_m2r_q;
    assign wb_reg_write_o  = wb_rw_q;

endmodule
